// File: rtl/hunter_packet_tx.sv
// hunter_packet_tx: Hunter fan remote-control packet transmitter.
// Serialises LEAD_SYMS zero symbols, the fixed device ID and a latched payload
// (both LSB first) as three-tick PWM symbols (0, data, 1) at a divided tick
// rate. Each start sends REPEAT packets separated by GAP_TICKS low ticks,
// followed by one low FINISH tick carrying the done pulse.
// Optional feature macro: HUNTER_TX_ABORT_EN adds the abort input, which
// cancels a busy transfer without a done pulse.
module hunter_packet_tx #(
    parameter int unsigned          CLK_DIV       = 2048,
    parameter int unsigned          ID_WIDTH      = 4,
    parameter logic [ID_WIDTH-1:0]  ID            = 4'b1010,
    parameter int unsigned          PAYLOAD_WIDTH = 7,
    parameter int unsigned          LEAD_SYMS     = 2,
    parameter int unsigned          REPEAT        = 3,
    parameter int unsigned          GAP_TICKS     = 30
) (
    input  logic                     ref_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
`ifdef HUNTER_TX_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned NSYM  = LEAD_SYMS + ID_WIDTH + PAYLOAD_WIDTH;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned REP_W = $clog2(REPEAT + 1);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [SYM_W-1:0] SYM_LAST   = SYM_W'(NSYM - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_TICKS - 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT - 1);

    // State meaning: what the next tick will emit.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [SYM_W-1:0]           sym_q, sym_d;
    logic [1:0]                 phase_q, phase_d;
    logic [REP_W-1:0]           rep_q, rep_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [PAYLOAD_WIDTH-1:0]   payload_q, payload_d;
    logic                       out_q, out_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       accept_c;
    logic                       tick_c;
    logic                       kill_c;
    logic                       last_sym_c;
    logic                       last_rep_c;
    logic                       gap_end_c;
    logic                       sym_bit_c;
    logic [NSYM-1:0]            frame_c;

    // Handshake and sequencing conditions.
    assign accept_c   = start && !busy_q;
    assign tick_c     = (state_q != S_IDLE) && (div_q == '0);
    assign last_sym_c = (sym_q == SYM_LAST) && (phase_q == 2'd2);
    assign last_rep_c = (rep_q == REP_LAST);
    assign gap_end_c  = (gap_q == GAP_LAST);

`ifdef HUNTER_TX_ABORT_EN
    assign kill_c = abort && busy_q;
`else
    assign kill_c = 1'b0;
`endif

    // Packet image: lead zeros, then ID, then latched payload, LSB first.
    always_comb begin
        frame_c = '0;
        frame_c[LEAD_SYMS +: ID_WIDTH]                 = ID;
        frame_c[LEAD_SYMS + ID_WIDTH +: PAYLOAD_WIDTH] = payload_q;
    end

    // PWM level for the current symbol phase.
    always_comb begin
        sym_bit_c = 1'b0;
        unique case (phase_q)
            2'd0:    sym_bit_c = 1'b0;
            2'd1:    sym_bit_c = frame_c[sym_q];
            default: sym_bit_c = 1'b1;
        endcase
    end

    // State register; reset has priority over every input.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions other than accept happen on ticks.
    always_comb begin
        state_d = state_q;
        if (kill_c) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (tick_c && last_sym_c) begin
                        state_d = last_rep_c ? S_FINISH : S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick_c && gap_end_c) begin
                        state_d = S_SEND;
                    end
                end
                S_FINISH: begin
                    if (tick_c) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values: divider, counters, payload latch, pins.
    always_comb begin
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        payload_d = payload_q;
        div_d     = div_q;
        sym_d     = sym_q;
        phase_d   = phase_q;
        rep_d     = rep_q;
        gap_d     = gap_q;

        if (kill_c) begin
            out_d   = 1'b0;
            busy_d  = 1'b0;
            div_d   = '0;
            sym_d   = '0;
            phase_d = '0;
            rep_d   = '0;
            gap_d   = '0;
        end else begin
            if (state_q != S_IDLE) begin
                div_d = tick_c ? DIV_RELOAD : div_q - DIV_W'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    // Busy is still high here during the done cycle, so a
                    // start on that cycle is not accepted.
                    busy_d = 1'b0;
                    if (accept_c) begin
                        busy_d    = 1'b1;
                        payload_d = payload;
                        div_d     = '0;
                        sym_d     = '0;
                        phase_d   = '0;
                        rep_d     = '0;
                        gap_d     = '0;
                    end
                end
                S_SEND: begin
                    if (tick_c) begin
                        out_d = sym_bit_c;
                        if (phase_q == 2'd2) begin
                            phase_d = '0;
                            if (sym_q == SYM_LAST) begin
                                sym_d = '0;
                                gap_d = '0;
                                if (!last_rep_c) begin
                                    rep_d = rep_q + REP_W'(1);
                                end
                            end else begin
                                sym_d = sym_q + SYM_W'(1);
                            end
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (tick_c) begin
                        out_d = 1'b0;
                        gap_d = gap_end_c ? '0 : gap_q + GAP_W'(1);
                    end
                end
                S_FINISH: begin
                    if (tick_c) begin
                        out_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    out_d  = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            div_q     <= '0;
            sym_q     <= '0;
            phase_q   <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            payload_q <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            sym_q     <= sym_d;
            phase_q   <= phase_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            payload_q <= payload_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hunter_packet_tx.sv
// tb_hunter_packet_tx: two transmitters (REPEAT=2 and REPEAT=1, CLK_DIV=4)
// driven by shared inputs, checked every cycle against a closed-form timing
// model, plus hand-computed literal expectations.
module tb_hunter_packet_tx;

    localparam int CD   = 4;
    localparam int NSYM = 13;
    localparam int GAP  = 30;
    localparam int LEAD = 2;
    localparam int IDW  = 4;
    localparam logic [3:0] IDV = 4'b1010;

    logic       ref_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [6:0] payload = 7'd0;
    logic       out0, busy0, done0;
    logic       out1, busy1, done1;

    always #5 ref_clk = ~ref_clk;

    hunter_packet_tx #(.CLK_DIV(CD), .REPEAT(2), .GAP_TICKS(GAP)) dut0 (
        .ref_clk (ref_clk),
        .reset   (reset),
        .start   (start),
        .payload (payload),
`ifdef HUNTER_TX_ABORT_EN
        .abort   (abort),
`endif
        .out     (out0),
        .busy    (busy0),
        .done    (done0)
    );

    hunter_packet_tx #(.CLK_DIV(CD), .REPEAT(1), .GAP_TICKS(GAP)) dut1 (
        .ref_clk (ref_clk),
        .reset   (reset),
        .start   (start),
        .payload (payload),
`ifdef HUNTER_TX_ABORT_EN
        .abort   (abort),
`endif
        .out     (out1),
        .busy    (busy1),
        .done    (done1)
    );

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    bit   act[2];
    int   st[2];
    logic [6:0] pl[2];

    function automatic int reps(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int total_ticks(int i);
        return reps(i) * 3 * NSYM + (reps(i) - 1) * GAP + 1;
    endfunction

    function automatic int done_off(int i);
        return 1 + (total_ticks(i) - 1) * CD;
    endfunction

    function automatic bit model_busy(int i);
        return act[i] && ((cyc - st[i]) <= done_off(i));
    endfunction

    function automatic bit sym_data(logic [6:0] p, int s);
        if (s < LEAD) return 1'b0;
        if (s < LEAD + IDW) return IDV[s - LEAD];
        return p[s - LEAD - IDW];
    endfunction

    // Expected {out, busy, done} after the current edge.
    function automatic logic [2:0] model_exp(int i);
        int d, k, p, ph;
        logic o;
        if (!act[i]) return 3'b000;
        d = cyc - st[i];
        if (d > done_off(i)) return 3'b000;
        o = 1'b0;
        if (d >= 1) begin
            k = (d - 1) / CD;
            if (k < total_ticks(i) - 1) begin
                p = k % (3 * NSYM + GAP);
                if (p < 3 * NSYM) begin
                    ph = p % 3;
                    o  = (ph == 0) ? 1'b0 : (ph == 2) ? 1'b1 : sym_data(pl[i], p / 3);
                end
            end
        end
        return {o, 1'b1, (d == done_off(i))};
    endfunction

    // Model update on each edge; inputs are stable here (driven at negedge).
    always @(posedge ref_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] = 1'b0;
            end else if (abort && model_busy(i)) begin
                act[i] = 1'b0;
            end else if (start && !model_busy(i)) begin
                act[i] = 1'b1;
                st[i]  = cyc + 1;
                pl[i]  = payload;
            end
        end
        cyc = cyc + 1;
    end

    task automatic check1(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge ref_clk) begin
        logic [2:0] e0, e1;
        if (chk_en) begin
            e0 = model_exp(0);
            e1 = model_exp(1);
            check1("model_out0",  out0,  e0[2]);
            check1("model_busy0", busy0, e0[1]);
            check1("model_done0", done0, e0[0]);
            check1("model_out1",  out1,  e1[2]);
            check1("model_busy1", busy1, e1[1]);
            check1("model_done1", done1, e1[0]);
        end
    end

    task automatic start_pulse(input logic [6:0] p, output int n);
        start   = 1'b1;
        payload = p;
        n       = cyc + 1;
        @(negedge ref_clk);
        start   = 1'b0;
        payload = ~p;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge ref_clk);
    endtask

    task automatic wait_done(input int i, output int when);
        when = -1;
        for (int w = 0; w < 1000; w++) begin
            if ((i == 0) ? done0 : done1) begin
                when = cyc;
                break;
            end
            @(negedge ref_clk);
        end
    endtask

    initial begin
        int n, m, w, nd;
        logic [12:0] exp_seq;
        exp_seq = 13'b1001111101000;

        reset = 1'b1;
        repeat (2) @(negedge ref_clk);
        chk_en = 1'b1;
        check1("reset_out0",  out0,  1'b0);
        check1("reset_busy0", busy0, 1'b0);
        check1("reset_done0", done0, 1'b0);
        @(negedge ref_clk);
        reset = 1'b0;
        @(negedge ref_clk);

        // Basic packet, ignored mid-packet restart, then restart after done.
        start_pulse(7'b1001111, n);
        for (int s = 0; s < NSYM; s++) begin
            if (s == 5) begin
                wait_until(n + 59);
                start   = 1'b1;
                payload = 7'b0110000;
                @(negedge ref_clk);
                start   = 1'b0;
            end
            wait_until(n + 5 + 12 * s);
            check1($sformatf("phase1_sym%0d", s), out1, exp_seq[s]);
        end
        wait_done(1, w);
        check_int("done1_time", w, n + 157);
        @(negedge ref_clk);
        check1("busy1_fall", busy1, 1'b0);
        start_pulse(7'b0110011, m);
        wait_until(m + 5 + 12 * 6);
        check1("new_payload_sym6", out1, 1'b1);
        wait_until(m + 5 + 12 * 8);
        check1("new_payload_sym8", out1, 1'b0);
        wait_done(0, w);
        check_int("done0_time", w, n + 433);
        repeat (3) @(negedge ref_clk);

        // Reset at tick 20 of a packet.
        start_pulse(7'b0101010, n);
        wait_until(n + 1 + 20 * CD);
        reset = 1'b1;
        @(negedge ref_clk);
        reset = 1'b0;
        check1("rst_mid_out0",  out0,  1'b0);
        check1("rst_mid_busy0", busy0, 1'b0);
        check1("rst_mid_busy1", busy1, 1'b0);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ref_clk);
            if (done0 || done1) nd++;
        end
        check_int("no_done_after_reset", nd, 0);

        // Reset and start together: reset wins.
        reset   = 1'b1;
        start   = 1'b1;
        payload = 7'b1111111;
        @(negedge ref_clk);
        reset = 1'b0;
        start = 1'b0;
        check1("rst_start_busy0", busy0, 1'b0);
        @(negedge ref_clk);
        check1("rst_start_busy0_late", busy0, 1'b0);
        check1("rst_start_busy1_late", busy1, 1'b0);

`ifdef HUNTER_TX_ABORT_EN
        // Abort in the inter-packet gap, then start+abort together while idle.
        start_pulse(7'b1110001, n);
        wait_until(n + 1 + 50 * CD);
        abort = 1'b1;
        @(negedge ref_clk);
        abort = 1'b0;
        check1("abort_out0",  out0,  1'b0);
        check1("abort_busy0", busy0, 1'b0);
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge ref_clk);
            if (done0) nd++;
        end
        check_int("no_done_after_abort", nd, 0);
        start   = 1'b1;
        abort   = 1'b1;
        payload = 7'b0011100;
        n       = cyc + 1;
        @(negedge ref_clk);
        start = 1'b0;
        abort = 1'b0;
        check1("idle_abort_start_busy0", busy0, 1'b1);
        wait_done(1, w);
        check_int("post_abort_done1_time", w, n + 157);
        wait_done(0, w);
        check_int("post_abort_done0_time", w, n + 433);
`endif

        repeat (5) @(negedge ref_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hunter_packet_tx.md
# hunter_packet_tx

Parametrised transmitter for the Hunter fan remote-control protocol. It serialises a fixed device ID and a caller-supplied payload into three-tick PWM symbols at a divided protocol rate, and repeats each packet a configurable number of times with low gaps between them. It has a start/busy/done handshake. It sits between the command decoder and the RF/IR driver pin, and replaces the fixed-command, single-shot packet generator.

## Interface
- CLK_DIV, 2048, ref_clk cycles per protocol tick; must be ≥1.
- ID_WIDTH, 4, device ID bits.
- ID, 4'b1010, device ID value, ID_WIDTH bits.
- PAYLOAD_WIDTH, 7, payload bits.
- LEAD_SYMS, 2, leading zero-data symbols per packet.
- REPEAT, 3, packets sent per start; must be ≥1.
- GAP_TICKS, 30, low ticks between repeated packets; must be ≥1.
- ref_clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; has priority over every other input.
- start  in  1  single-cycle request; accepted only when busy=0.
- payload  in  PAYLOAD_WIDTH  packet payload; sampled on the cycle start is accepted.
- out  out  1  serial protocol output.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse when the final packet completes.
- abort  in  1  present only with HUNTER_TX_ABORT_EN (see Configuration).

## Operation
- Reset values: out=0, busy=0, done=0, state IDLE. Tick divider and all counters are cleared.
- States:
  - IDLE: on start, go to SEND and latch payload.
  - SEND: go to GAP after the last symbol if packets remain; otherwise go to FINISH.
  - GAP: go to SEND after GAP_TICKS ticks.
  - FINISH: go to IDLE.
- Packet format: NSYM = LEAD_SYMS + ID_WIDTH + PAYLOAD_WIDTH symbols, in this order:
  - LEAD_SYMS symbols with data 0;
  - ID, LSB first;
  - latched payload, LSB first.
- Symbol format: three consecutive ticks. Phase 0 drives out=0, phase 1 drives out=data, phase 2 drives out=1.
- GAP: out=0 for exactly GAP_TICKS ticks, then the next packet starts at symbol 0 / phase 0.
- FINISH: a single tick that drives out=0. done=1 on that cycle; busy drops on the next cycle.
- Start while busy=1 is ignored. It does not re-latch payload or restart.
- Changes on payload after acceptance have no effect on the transfer in progress.
- Counter widths: divider $clog2(CLK_DIV) (min 1); symbol index $clog2(NSYM); phase 2 bits, wrapping 2→0; repeat count $clog2(REPEAT+1).
- Reset mid-transfer: on the next edge, out=0, busy=0, IDLE, and no done pulse.
- Reset and start asserted on the same cycle: reset wins and start is dropped.

## Timing
- Start accepted at edge N: busy=1 from N. The divider is loaded so the first tick falls at N+1.
- Ticks then occur every CLK_DIV cycles, at N+1+k·CLK_DIV. out changes only on tick edges and is registered, with no combinational path from inputs.
- Packet duration: 3·NSYM ticks. With defaults, NSYM=13, so a packet is 39 ticks.
- Total ticks to done: REPEAT·3·NSYM + (REPEAT−1)·GAP_TICKS + 1. done asserts at edge N+1+(total−1)·CLK_DIV.
- A new start is accepted on the cycle after done, when busy=0.
- CLK_DIV=1: a tick occurs every cycle and the behaviour above holds unchanged.

## Configuration
- HUNTER_TX_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 while busy=1: on the next edge, out=0, busy=0, state IDLE, no done pulse.
  - abort while idle is ignored.
  - start and abort on the same idle cycle: abort has no effect and start is accepted.
- HUNTER_TX_ABORT_EN undefined: the abort port does not exist, and a transfer can be stopped only by reset.

## Test plan
- CLK_DIV=4, REPEAT=1, payload=7'b1001111, start at N:
  - The phase-1 data sequence is 0,0,0,1,0,1,1,1,1,1,0,0,1.
  - Phase 0 is always 0 and phase 2 is always 1.
  - done pulses at N+157 and busy falls at N+158.
- CLK_DIV=4, REPEAT=2, GAP_TICKS=30:
  - out stays 0 for 120 cycles between the two packets.
  - The two packets are bit-identical.
  - done at N+433.
- Start pulsed again mid-packet with a different payload: output unchanged and done time unchanged.
- Start at the done+1 cycle: accepted, and the new packet follows the new payload.
- Reset at tick 20 of the packet: out=0 and busy=0 on the next edge, with no done pulse.
- Reset and start on the same cycle: the transfer stays idle.
- With HUNTER_TX_ABORT_EN: abort mid-gap gives out=0, busy=0 on the next edge and no done pulse. A following start produces a full, correct transfer.
